// File: rtl/morph_ctrl_if.sv
// Pixel-timing, config handshake and status bundle between the morphology controller and its neighbours.
interface morph_ctrl_if #(
   parameter int CNT_W = 12
);
   logic             in_vsync;
   logic             in_de;
   logic             cfg_valid;
   logic [1:0]       cfg_mode;
   logic             cfg_ready;
   logic             matrix_de;
   logic [1:0]       mode_act;
   logic             border_mask;
   logic [CNT_W-1:0] col_cnt;
   logic [CNT_W-1:0] row_cnt;
   logic             frame_done;
   logic             frame_err;

   modport master (
      output in_vsync, in_de, cfg_valid, cfg_mode,
      input  cfg_ready, matrix_de, mode_act, border_mask, col_cnt, row_cnt, frame_done, frame_err
   );

   modport slave (
      input  in_vsync, in_de, cfg_valid, cfg_mode,
      output cfg_ready, matrix_de, mode_act, border_mask, col_cnt, row_cnt, frame_done, frame_err
   );
endinterface

// File: rtl/morph_ctrl.sv
// Frame controller for the 3x3 morphology datapath: position tracking, window-valid gating, frame-boundary mode latch.
// matrix_de is combinational from in_de; border_mask trails it by PIPE_LAT cycles; a config slot holds one pending mode.
module morph_ctrl #(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int CNT_W    = 12,
   parameter int PIPE_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   morph_ctrl_if.slave bus
);
   typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   localparam logic [CNT_W-1:0] C_W      = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] C_W_LAST = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(IMG_H - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_vsync;
   logic                r_de;
   logic [CNT_W-1:0]    r_col;
   logic [CNT_W-1:0]    r_row;
   logic [CNT_W-1:0]    w_col_nxt;
   logic [CNT_W-1:0]    w_row_nxt;
   logic                w_vs_rise;
   logic                w_de_fall;
   logic                w_err_set;
   logic                w_frame_done;
   logic                w_matrix_de;
   logic                w_border_raw;
   logic                w_cfg_ready;
   logic                w_cfg_xfer;
   logic                r_pend_vld;
   logic [1:0]          r_pend_mode;
   logic [1:0]          r_mode_act;
   logic                r_err;
   logic [PIPE_LAT-1:0] r_bm_sr;

   assign w_vs_rise    = bus.in_vsync & ~r_vsync;
   assign w_de_fall    = ~bus.in_de & r_de;
   assign w_matrix_de  = ~rst & (r_state == S_ACTIVE) & bus.in_de;
   assign w_cfg_ready  = ~rst & ~r_pend_vld;
   assign w_cfg_xfer   = bus.cfg_valid & w_cfg_ready;
   assign w_border_raw = w_matrix_de & ((r_col == '0) | (r_col == C_W_LAST) |
                                        (r_row == '0) | (r_row == C_H_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_col_nxt    = r_col;
      w_row_nxt    = r_row;
      w_err_set    = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_col_nxt = '0;
            w_row_nxt = '0;
            if (w_vs_rise) begin
               w_state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            // An early vsync restarts the frame in place rather than dropping to IDLE.
            if (w_vs_rise) begin
               w_err_set = 1'b1;
               w_col_nxt = '0;
               w_row_nxt = '0;
            end else if (bus.in_de) begin
               if (r_col != '1) begin
                  w_col_nxt = r_col + 1'b1;
               end
            end else if (w_de_fall) begin
               w_err_set = (r_col != C_W);
               w_col_nxt = '0;
               if (r_row == C_H_LAST) begin
                  w_row_nxt    = '0;
                  w_frame_done = 1'b1;
                  w_state_nxt  = S_IDLE;
               end else begin
                  w_row_nxt = r_row + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vsync <= 1'b0;
         r_de    <= 1'b0;
         r_col   <= '0;
         r_row   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_vsync <= bus.in_vsync;
         r_de    <= bus.in_de;
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   // A transfer only happens with the slot empty, so it never collides with the vsync apply.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_vld  <= 1'b0;
         r_pend_mode <= 2'd0;
         r_mode_act  <= 2'd0;
      end else if (w_vs_rise && r_pend_vld) begin
         r_mode_act <= (r_pend_mode == 2'd3) ? 2'd0 : r_pend_mode;
         r_pend_vld <= 1'b0;
      end else if (w_cfg_xfer) begin
         r_pend_mode <= bus.cfg_mode;
         r_pend_vld  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bm_sr <= '0;
      end else begin
         r_bm_sr[0] <= w_border_raw;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_bm_sr[i] <= r_bm_sr[i-1];
         end
      end
   end

   assign bus.cfg_ready   = w_cfg_ready;
   assign bus.matrix_de   = w_matrix_de;
   assign bus.mode_act    = r_mode_act;
   assign bus.border_mask = r_bm_sr[PIPE_LAT-1];
   assign bus.col_cnt     = r_col;
   assign bus.row_cnt     = r_row;
   assign bus.frame_done  = ~rst & w_frame_done;
   assign bus.frame_err   = r_err;
endmodule

// File: tb/tb_morph_ctrl.sv
// Directed bench for morph_ctrl on an 8x4 image: vector table for reset/nominal frame, hand sequences for config, errors and reset.
module tb_morph_ctrl;
   localparam int W     = 8;
   localparam int H     = 4;
   localparam int CNT_W = 12;
   localparam int LAT   = 3;

   typedef struct {
      logic       vs;
      logic       de;
      logic       cv;
      logic [1:0] cm;
      logic       mde;
      int         col;
      int         row;
      logic       fd;
      logic       bm;
      logic       err;
      logic       rdy;
      logic [1:0] mode;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   vec_t tbl[$];
   bit   rawq[$];

   always #5 clk = ~clk;

   morph_ctrl_if #(.CNT_W(CNT_W)) m_if ();

   morph_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CNT_W), .PIPE_LAT(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic vs, input logic de, input logic cv, input logic [1:0] cm);
      @(posedge clk);
      #1;
      rst            = r;
      m_if.in_vsync  = vs;
      m_if.in_de     = de;
      m_if.cfg_valid = cv;
      m_if.cfg_mode  = cm;
      #1;
   endtask

   task automatic line(input int n);
      for (int c = 0; c < n; c++) cyc(0, 0, 1, 0, 2'd0);
      repeat (4) cyc(0, 0, 0, 0, 2'd0);
   endtask

   task automatic frame_rest();
      for (int l = 0; l < H; l++) line(W);
   endtask

   // Expected border_mask is the geometric edge test of the pixel LAT cycles earlier.
   function automatic void push(input logic vs, input logic de, input logic mde, input int col, input int row, input logic fd);
      vec_t v;
      v.vs = vs; v.de = de; v.cv = 1'b0; v.cm = 2'd0;
      v.mde = mde; v.col = col; v.row = row; v.fd = fd;
      v.bm  = (rawq.size() >= LAT) ? rawq[rawq.size()-LAT] : 1'b0;
      v.err = 1'b0; v.rdy = 1'b1; v.mode = 2'd0;
      rawq.push_back(mde && (col == 0 || col == W-1 || row == 0 || row == H-1));
      tbl.push_back(v);
   endfunction

   task automatic apply_vec(input int i, input vec_t v);
      cyc(0, v.vs, v.de, v.cv, v.cm);
      chk($sformatf("v%0d.matrix_de", i), m_if.matrix_de, v.mde);
      chk($sformatf("v%0d.col_cnt", i), m_if.col_cnt, v.col);
      chk($sformatf("v%0d.row_cnt", i), m_if.row_cnt, v.row);
      chk($sformatf("v%0d.frame_done", i), m_if.frame_done, v.fd);
      chk($sformatf("v%0d.border_mask", i), m_if.border_mask, v.bm);
      chk($sformatf("v%0d.frame_err", i), m_if.frame_err, v.err);
      chk($sformatf("v%0d.cfg_ready", i), m_if.cfg_ready, v.rdy);
      chk($sformatf("v%0d.mode_act", i), m_if.mode_act, v.mode);
   endtask

   task automatic reset_at(input int row, input int col);
      cyc(0, 1, 0, 0, 2'd0);
      cyc(0, 0, 0, 1, 2'd1);
      cyc(0, 0, 0, 0, 2'd0);
      chk("rst_pend_set", m_if.cfg_ready, 0);
      for (int r = 0; r < row; r++) line(W);
      for (int c = 0; c < col; c++) cyc(0, 0, 1, 0, 2'd0);
      cyc(1, 0, 1, 0, 2'd0);
      chk("rst_pre_col", m_if.col_cnt, col);
      chk("rst_pre_row", m_if.row_cnt, row);
      chk("rst_pre_bm", m_if.border_mask, (row == 0) ? 1 : 0);
      for (int k = 0; k < LAT; k++) begin
         cyc(0, 0, 1, 0, 2'd0);
         chk($sformatf("rst_post%0d_mde", k), m_if.matrix_de, 0);
         chk($sformatf("rst_post%0d_bm", k), m_if.border_mask, 0);
         chk($sformatf("rst_post%0d_col", k), m_if.col_cnt, 0);
         chk($sformatf("rst_post%0d_row", k), m_if.row_cnt, 0);
         chk($sformatf("rst_post%0d_rdy", k), m_if.cfg_ready, 1);
         chk($sformatf("rst_post%0d_err", k), m_if.frame_err, 0);
         chk($sformatf("rst_post%0d_mode", k), m_if.mode_act, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "time limit");
   end

   initial begin
      m_if.in_vsync  = 1'b0;
      m_if.in_de     = 1'b0;
      m_if.cfg_valid = 1'b0;
      m_if.cfg_mode  = 2'd0;

      // Released from reset with de toggling and no vsync: nothing moves.
      push(0, 1, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0); push(0, 1, 0, 0, 0, 0);
      push(0, 1, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0);
      // Nominal frame: vsync, one idle cycle, 4 lines of 8 pixels with 4-cycle gaps.
      push(1, 0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0, 0);
      for (int l = 0; l < H; l++) begin
         for (int c = 0; c < W; c++) push(0, 1, 1, c, l, 0);
         push(0, 0, 0, W, l, (l == H-1));
         for (int g = 1; g < 4; g++) push(0, 0, 0, 0, (l == H-1) ? 0 : l + 1, 0);
      end
      // Back in IDLE: a full de line must be ignored.
      for (int c = 0; c < W; c++) push(0, 1, 0, 0, 0, 0);
      for (int g = 0; g < 4; g++) push(0, 0, 0, 0, 0, 0);

      repeat (3) cyc(1, 0, 0, 0, 2'd0);
      for (int i = 0; i < tbl.size(); i++) apply_vec(i, tbl[i]);

      // Mode change mid-frame takes effect at the next vsync.
      cyc(0, 1, 0, 0, 2'd0);
      cyc(0, 0, 0, 1, 2'd1);
      chk("cfg_rdy_empty", m_if.cfg_ready, 1);
      cyc(0, 0, 0, 0, 2'd0);
      chk("cfg_rdy_drop", m_if.cfg_ready, 0);
      chk("mode_wait", m_if.mode_act, 0);
      frame_rest();
      chk("mode_wait_eof", m_if.mode_act, 0);
      chk("cfg_rdy_eof", m_if.cfg_ready, 0);
      cyc(0, 1, 0, 0, 2'd0);
      chk("mode_vs_cycle", m_if.mode_act, 0);
      cyc(0, 0, 0, 1, 2'd3);
      chk("mode_erosion", m_if.mode_act, 1);
      chk("cfg_rdy_back", m_if.cfg_ready, 1);
      cyc(0, 0, 0, 0, 2'd0);
      chk("mode_keep_1", m_if.mode_act, 1);
      frame_rest();
      cyc(0, 1, 0, 0, 2'd0);
      cyc(0, 0, 0, 0, 2'd0);
      chk("mode3_bypass", m_if.mode_act, 0);
      chk("cfg_rdy_m3", m_if.cfg_ready, 1);
      frame_rest();

      // Config transfer coincident with vsync waits a whole frame.
      cyc(0, 1, 0, 1, 2'd2);
      chk("simul_rdy", m_if.cfg_ready, 1);
      cyc(0, 0, 0, 0, 2'd0);
      chk("simul_hold", m_if.mode_act, 0);
      chk("simul_pend", m_if.cfg_ready, 0);
      frame_rest();
      cyc(0, 1, 0, 0, 2'd0);
      cyc(0, 0, 0, 0, 2'd0);
      chk("simul_apply", m_if.mode_act, 2);
      chk("simul_rdy_back", m_if.cfg_ready, 1);
      frame_rest();
      chk("no_err_legal", m_if.frame_err, 0);

      // Short line of 7 pixels on row 1.
      cyc(0, 1, 0, 0, 2'd0);
      cyc(0, 0, 0, 0, 2'd0);
      line(W);
      for (int c = 0; c < W-1; c++) cyc(0, 0, 1, 0, 2'd0);
      cyc(0, 0, 0, 0, 2'd0);
      chk("short_col", m_if.col_cnt, W-1);
      chk("short_err_pre", m_if.frame_err, 0);
      cyc(0, 0, 0, 0, 2'd0);
      chk("short_err", m_if.frame_err, 1);
      chk("short_row", m_if.row_cnt, 2);
      chk("short_col_clr", m_if.col_cnt, 0);
      repeat (2) cyc(0, 0, 0, 0, 2'd0);

      reset_at(0, 4);

      // Early vsync at row 2.
      cyc(0, 0, 0, 0, 2'd0);
      cyc(0, 1, 0, 0, 2'd0);
      cyc(0, 0, 0, 0, 2'd0);
      line(W);
      line(W);
      chk("early_row_pre", m_if.row_cnt, 2);
      chk("early_err_pre", m_if.frame_err, 0);
      cyc(0, 1, 0, 0, 2'd0);
      cyc(0, 0, 1, 0, 2'd0);
      chk("early_err", m_if.frame_err, 1);
      chk("early_col", m_if.col_cnt, 0);
      chk("early_row", m_if.row_cnt, 0);
      chk("early_active", m_if.matrix_de, 1);
      cyc(0, 0, 1, 0, 2'd0);
      chk("early_count", m_if.col_cnt, 1);
      repeat (2) cyc(0, 0, 0, 0, 2'd0);

      reset_at(1, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/morph_ctrl.md
Name: morph_ctrl

Overview:
- Frame-level controller for the 3x3 morphology datapath, which comprises the erosion and dilation units fed by the line-buffer matrix generator.
- Tracks pixel position from upstream timing and gates the window-valid strobe into the datapath.
- Latches operating mode changes only at frame boundaries.
- Produces a border mask aligned to the datapath result so downstream logic can zero the invalid edge pixels of the 3x3 window.

Parameters:
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.
- CNT_W, 12, width of the column and row counters; must satisfy 2^CNT_W > max(IMG_W, IMG_H).
- PIPE_LAT, 3, datapath latency in cycles from matrix_de to result-valid (the erosion unit is 3).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_vsync  in  1  frame sync, active-high level; its rising edge marks frame start.
- in_de  in  1  window-valid from the matrix generator, high for IMG_W cycles per line.
- cfg_valid  in  1  mode-update request.
- cfg_mode  in  2  requested mode: 0 bypass, 1 erosion, 2 dilation, 3 reserved (treated as bypass).
- cfg_ready  out  1  high when the pending-config slot is empty.
- matrix_de  out  1  gated window-valid into the datapath.
- mode_act  out  2  active mode; stable for a whole frame; drives the result mux select.
- border_mask  out  1  high when the result on the current cycle is a frame-edge pixel; aligned with the datapath result-valid.
- col_cnt  out  CNT_W  column index of the current in_de pixel.
- row_cnt  out  CNT_W  current line index.
- frame_done  out  1  one-cycle pulse after the last pixel of line IMG_H-1.
- frame_err  out  1  sticky error flag: short/long line or early vsync.

Behaviour:
- **Reset values:** when rst=1, all outputs are 0, mode_act=0, pending slot is empty, state is IDLE. rst dominates every other input.
- **Edge detection:** in_vsync and in_de are each registered once. Edges are detected on the registered copy versus the live input.
- **States:**
  - IDLE: matrix_de=0, counters hold 0. A vsync rising edge moves to ACTIVE.
  - ACTIVE: matrix_de = in_de (combinational AND with state==ACTIVE). Counting rules:
    - Each cycle with in_de=1: col_cnt increments.
    - On the in_de falling edge: if col_cnt != IMG_W then frame_err is set. Then col_cnt is cleared and row_cnt increments.
    - When row_cnt would reach IMG_H: frame_done pulses for 1 cycle, counters are cleared, and the state goes to IDLE.
    - A vsync rising edge in ACTIVE (early frame) sets frame_err, clears counters, stays in ACTIVE, and applies the pending config as a normal frame start.
  - In IDLE, in_de pulses are ignored: no counting and matrix_de stays 0.
- **Config handshake:**
  - cfg_ready = ~pend_valid.
  - Transfer occurs when cfg_valid & cfg_ready; cfg_mode is stored and pend_valid is set.
  - On every vsync rising edge: if pend_valid, then mode_act <= pending mode (3 maps to 0) and pend_valid is cleared.
  - If a transfer and a vsync edge happen in the same cycle, the new value waits for the following frame; mode_act is unchanged that cycle.
- **Border mask:**
  - Raw border = in_de & (col_cnt==0 | col_cnt==IMG_W-1 | row_cnt==0 | row_cnt==IMG_H-1), evaluated on the pre-increment counter values.
  - The raw term is delayed PIPE_LAT cycles through a shift register (cleared by rst) to produce border_mask.
  - border_mask is therefore coincident with matrix_de delayed PIPE_LAT.
- **frame_err:** cleared only by rst.
- **Counter widths:** counters never wrap in legal operation. An overlong line saturates col_cnt at 2^CNT_W-1 and is flagged at the line end.

Test Plan:
- Bench parameters for all scenarios: IMG_W=8, IMG_H=4.
- Reset then idle: hold rst=1 for 3 cycles, then release with in_de toggling and no vsync -> matrix_de=0, mode_act=0, cfg_ready=1, all counters 0.
- Nominal frame:
  - Stimulus: vsync pulse, then 4 lines of 8 de cycles with 4-cycle gaps.
  - Required: matrix_de mirrors in_de; col_cnt runs 0..7; row_cnt runs 0..3.
  - Required: border_mask high for all of rows 0 and 3 and for cols 0 and 7 of rows 1-2, each PIPE_LAT=3 cycles after matrix_de.
  - Required: frame_done pulses once, 1 cycle after the last de; state returns to IDLE.
- Mode change: cfg_valid with cfg_mode=1 mid-frame.
  - cfg_ready drops the next cycle.
  - mode_act stays 0 until the next vsync rise, becomes 1 that cycle, and cfg_ready returns to 1.
  - cfg_mode=3 then yields mode_act=0.
- Simultaneous config and vsync: cfg transfer in the same cycle as the vsync rise -> mode_act is unchanged for that frame and updates at the following vsync.
- Errors: a 7-pixel line -> frame_err=1 at that line's de fall. Separately, a vsync rise at row 2 -> frame_err=1 and counters restart at 0.
- Reset mid-frame: assert rst at row 1, col 4 -> next cycle matrix_de=0, border_mask shift register empty, pend_valid=0, state IDLE.
